// File: rtl/upg_loader_pkg.sv
// upg_pkg: shared state encoding and constants for the UART program loader.
// Checksum-related codes are used only when UPG_LOADER_CHECKSUM_EN is defined.
package upg_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_HDR_TGT,
      S_HDR_CNT0,
      S_HDR_CNT1,
      S_DATA,
      S_WRITE,
      S_CHK,
      S_DONE,
      S_ERR
   } upg_state_t;

   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_TGT  = 2'd1;
   localparam logic [1:0] ERR_CNT  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;
   // A bad checksum shares the top error code with timeout.
   localparam logic [1:0] ERR_CHK  = 2'd3;

   localparam logic TGT_INSTR = 1'b0;
   localparam logic TGT_DATA  = 1'b1;

endpackage

// File: rtl/upg_timeout.sv
// upg_timeout: idle-gap down-counter; reloads on clear, flags expiry at zero.
// Expiry is asserted CYCLES cycles after the last clear.
module upg_timeout #(
   parameter int CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   output logic o_expire
);

   localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
   localparam logic [W-1:0] LOAD = W'(CYCLES - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= LOAD;
      end else if (i_clr) begin
         r_cnt <= LOAD;
      end else if (r_cnt != '0) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/upg_loader.sv
// upg_loader: UART frame sequencer for instruction/data memory download.
// Define UPG_LOADER_CHECKSUM_EN to require a trailing two's-complement checksum byte.
module upg_loader
   import upg_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter int MAX_WORDS      = 16384,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start_i,
   input  logic            rx_valid_i,
   input  logic [7:0]      rx_byte_i,
   output logic            upg_wen_o,
   output logic [ADDR_W:0] upg_adr_o,
   output logic [31:0]     upg_dat_o,
   output logic            upg_done_o,
   output logic            cpu_hold_o,
   output logic            busy_o,
   output logic [1:0]      err_o
);

`ifdef UPG_LOADER_CHECKSUM_EN
   localparam upg_state_t S_END = S_CHK;
`else
   localparam upg_state_t S_END = S_DONE;
`endif

   upg_state_t r_state;
   upg_state_t w_next;

   logic              r_tgt;
   logic [ADDR_W-1:0] r_idx;
   logic [1:0]        r_lane;
   logic [7:0]        r_cnt_lo;
   logic [15:0]       r_cnt;
   logic [31:0]       r_dat;
   logic [1:0]        r_err;

   logic        w_set_err;
   logic [1:0]  w_err_code;
   logic        w_start;
   logic        w_rx_state;
   logic        w_last;
   logic        w_expire;
   logic        w_tmo_clr;
   logic        w_tgt_ok;
   logic [16:0] w_cnt_full;

   assign w_cnt_full = {1'b0, rx_byte_i, r_cnt_lo};
   assign w_last     = (17'(r_idx) + 17'd1) == {1'b0, r_cnt};
   assign w_tgt_ok   = (rx_byte_i == {7'd0, TGT_INSTR}) ||
                       (rx_byte_i == {7'd0, TGT_DATA});
   assign w_start    = start_i &&
                       ((r_state == S_IDLE) || (r_state == S_ERR));
   assign w_rx_state = r_state inside
                       {S_HDR_TGT, S_HDR_CNT0, S_HDR_CNT1, S_DATA, S_CHK};

`ifdef UPG_LOADER_CHECKSUM_EN
   logic [7:0] r_sum;
   logic [7:0] w_sum_chk;
   logic       w_sum_add;
   assign w_sum_chk = r_sum + rx_byte_i;
   assign w_sum_add = rx_valid_i && ((r_state inside
                      {S_HDR_TGT, S_HDR_CNT0, S_HDR_CNT1, S_DATA}) ||
                      ((r_state == S_WRITE) && !w_last));
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_set_err  = 1'b0;
      w_err_code = ERR_NONE;
      unique case (r_state)
         S_IDLE: if (start_i) w_next = S_HDR_TGT;
         S_HDR_TGT: if (rx_valid_i) begin
            if (w_tgt_ok) begin
               w_next = S_HDR_CNT0;
            end else begin
               w_next     = S_ERR;
               w_set_err  = 1'b1;
               w_err_code = ERR_TGT;
            end
         end
         S_HDR_CNT0: if (rx_valid_i) w_next = S_HDR_CNT1;
         S_HDR_CNT1: if (rx_valid_i) begin
            if (w_cnt_full > 17'(MAX_WORDS)) begin
               w_next     = S_ERR;
               w_set_err  = 1'b1;
               w_err_code = ERR_CNT;
            end else if (w_cnt_full == '0) begin
               w_next = S_END;
            end else begin
               w_next = S_DATA;
            end
         end
         S_DATA: if (rx_valid_i && (r_lane == 2'd3)) w_next = S_WRITE;
         S_WRITE: w_next = w_last ? S_END : S_DATA;
`ifdef UPG_LOADER_CHECKSUM_EN
         S_CHK: if (rx_valid_i) begin
            if (w_sum_chk == 8'h00) begin
               w_next = S_DONE;
            end else begin
               w_next     = S_ERR;
               w_set_err  = 1'b1;
               w_err_code = ERR_CHK;
            end
         end
`endif
         S_DONE: w_next = S_IDLE;
         S_ERR: if (start_i) w_next = S_HDR_TGT;
         default: w_next = S_IDLE;
      endcase
      // A silent line inside a frame aborts the download.
      if (w_rx_state && !rx_valid_i && w_expire) begin
         w_next     = S_ERR;
         w_set_err  = 1'b1;
         w_err_code = ERR_TMO;
      end
   end

   assign w_tmo_clr = rx_valid_i || (w_next != r_state);

   upg_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_tmo (
      .clk      (clk),
      .rst_n    (rst),
      .i_clr    (w_tmo_clr),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_tgt    <= TGT_INSTR;
         r_idx    <= '0;
         r_lane   <= 2'd0;
         r_cnt_lo <= 8'd0;
         r_cnt    <= 16'd0;
         r_dat    <= 32'd0;
         r_err    <= ERR_NONE;
      end else begin
         if (w_set_err)    r_err <= w_err_code;
         else if (w_start) r_err <= ERR_NONE;
         if (w_start) begin
            r_idx  <= '0;
            r_lane <= 2'd0;
         end
         if (r_state == S_WRITE) r_idx <= r_idx + 1'b1;
         if (rx_valid_i) begin
            unique case (r_state)
               S_HDR_TGT:  if (w_tgt_ok) r_tgt <= rx_byte_i[0];
               S_HDR_CNT0: r_cnt_lo <= rx_byte_i;
               S_HDR_CNT1: begin
                  r_cnt  <= w_cnt_full[15:0];
                  r_lane <= 2'd0;
               end
               S_DATA: begin
                  r_dat[{r_lane, 3'b000} +: 8] <= rx_byte_i;
                  r_lane <= r_lane + 2'd1;
               end
               // Byte overlapping the write opens the next word.
               S_WRITE: if (!w_last) begin
                  r_dat[7:0] <= rx_byte_i;
                  r_lane     <= 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef UPG_LOADER_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           r_sum <= 8'd0;
      else if (w_start)   r_sum <= 8'd0;
      else if (w_sum_add) r_sum <= w_sum_chk;
   end
`endif

   assign upg_wen_o  = (r_state == S_WRITE);
   assign upg_adr_o  = {r_tgt, r_idx};
   assign upg_dat_o  = r_dat;
   assign upg_done_o = (r_state == S_IDLE);
   assign cpu_hold_o = (r_state != S_IDLE);
   assign busy_o     = (r_state != S_IDLE);
   assign err_o      = r_err;

endmodule

// File: tb/tb_upg_loader.sv
// tb_upg_loader: directed frames for upg_loader against a byte-position model.
// Frames gain a trailing checksum byte when UPG_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_upg_loader;

   localparam int ADDR_W = 14;
   localparam int MAX_W  = 16384;
   localparam int TMO    = 100;

   localparam int M_IDLE = 0;
   localparam int M_RX   = 1;
   localparam int M_WR   = 2;
   localparam int M_DONE = 3;
   localparam int M_ERR  = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            start_i = 1'b0;
   logic            rx_valid_i = 1'b0;
   logic [7:0]      rx_byte_i = 8'd0;
   logic            upg_wen_o;
   logic [ADDR_W:0] upg_adr_o;
   logic [31:0]     upg_dat_o;
   logic            upg_done_o;
   logic            cpu_hold_o;
   logic            busy_o;
   logic [1:0]      err_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   upg_loader #(
      .ADDR_W         (ADDR_W),
      .MAX_WORDS      (MAX_W),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .rx_valid_i (rx_valid_i),
      .rx_byte_i  (rx_byte_i),
      .upg_wen_o  (upg_wen_o),
      .upg_adr_o  (upg_adr_o),
      .upg_dat_o  (upg_dat_o),
      .upg_done_o (upg_done_o),
      .cpu_hold_o (cpu_hold_o),
      .busy_o     (busy_o),
      .err_o      (err_o)
   );

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: tracks position in the frame, not loader states.
   int          m_mode, m_pos, m_quiet, m_cnt, m_widx;
   bit          m_tgt, m_chk;
   logic [7:0]  m_lo, m_sum;
   logic [31:0] m_word;
   logic [1:0]  m_err;
   logic [31:0] m_wa[$];
   logic [31:0] m_wd[$];
   logic [31:0] d_wa[$];
   logic [31:0] d_wd[$];

   task automatic m_end();
`ifdef UPG_LOADER_CHECKSUM_EN
      m_chk = 1'b1;
`else
      m_mode = M_DONE;
`endif
   endtask

   task automatic m_take(input logic [7:0] b);
      logic [7:0] t;
      int d;
      if (m_chk) begin
         t = m_sum + b;
         if (t == 8'h00) m_mode = M_DONE;
         else begin m_mode = M_ERR; m_err = 2'd3; end
         return;
      end
      m_sum = m_sum + b;
      case (m_pos)
         0: if (b > 8'd1) begin m_mode = M_ERR; m_err = 2'd1; end
            else m_tgt = b[0];
         1: m_lo = b;
         2: begin
            m_cnt = {b, m_lo};
            if (m_cnt > MAX_W) begin m_mode = M_ERR; m_err = 2'd2; end
            else if (m_cnt == 0) m_end();
         end
         default: begin
            d = m_pos - 3;
            m_word[(d % 4) * 8 +: 8] = b;
            if (d % 4 == 3) m_mode = M_WR;
         end
      endcase
      m_pos++;
   endtask

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_mode = M_IDLE; m_err = 2'd0; m_quiet = 0; m_pos = 0;
         m_chk = 1'b0; m_widx = 0; m_cnt = 0; m_tgt = 1'b0; m_sum = 8'd0;
      end else begin
         case (m_mode)
            M_IDLE, M_ERR: if (start_i) begin
               m_mode = M_RX; m_pos = 0; m_err = 2'd0; m_quiet = 0;
               m_widx = 0; m_sum = 8'd0; m_chk = 1'b0;
            end
            M_RX: if (rx_valid_i) begin
               m_quiet = 0;
               m_take(rx_byte_i);
            end else begin
               m_quiet++;
               if (m_quiet >= TMO) begin m_mode = M_ERR; m_err = 2'd3; end
            end
            M_WR: begin
               m_wa.push_back({17'd0, m_tgt, 14'(m_widx)});
               m_wd.push_back(m_word);
               m_quiet = 0;
               m_widx++;
               if (m_widx == m_cnt) begin
                  m_mode = M_RX;
                  m_end();
               end else begin
                  m_mode = M_RX;
                  if (rx_valid_i) m_take(rx_byte_i);
               end
            end
            M_DONE: m_mode = M_IDLE;
            default: ;
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (rst) begin
         check("wen", 32'(upg_wen_o), 32'(m_mode == M_WR));
         check("done", 32'(upg_done_o), 32'(m_mode == M_IDLE));
         check("hold", 32'(cpu_hold_o), 32'(m_mode != M_IDLE));
         check("busy", 32'(busy_o), 32'(m_mode != M_IDLE));
         check("err", 32'(err_o), 32'(m_err));
         if (m_mode == M_WR) begin
            check("adr", 32'(upg_adr_o), {17'd0, m_tgt, 14'(m_widx)});
            check("dat", upg_dat_o, m_word);
         end
         if (upg_wen_o) begin
            d_wa.push_back(32'(upg_adr_o));
            d_wd.push_back(upg_dat_o);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      rx_valid_i = 1'b1;
      rx_byte_i  = b;
      tick();
      rx_valid_i = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic send_frame(input logic [7:0] f[$], input int gap,
                             input logic [7:0] chk_xor, input int mid_start);
      logic [7:0] s;
      s = 8'd0;
      foreach (f[i]) begin
         if (i == mid_start) pulse_start();
         send_byte(f[i], gap);
         s = s + f[i];
      end
`ifdef UPG_LOADER_CHECKSUM_EN
      repeat (2) tick();
      send_byte((8'd0 - s) ^ chk_xor, 0);
`else
      if (chk_xor != 8'd0) s = 8'd0;
`endif
   endtask

   task automatic clr_log();
      d_wa.delete();
      d_wd.delete();
      m_wa.delete();
      m_wd.delete();
   endtask

   task automatic chk_wr(input string nm, input int i,
                         input logic [31:0] adr, input logic [31:0] dat);
      check({nm, "_adr"}, (d_wa.size() > i) ? d_wa[i] : 32'hxxxxxxxx, adr);
      check({nm, "_dat"}, (d_wd.size() > i) ? d_wd[i] : 32'hxxxxxxxx, dat);
   endtask

   logic [7:0] fa[$];
   logic [7:0] fb[$];
   logic [7:0] fx[$];

   initial begin
      fa = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE};
      fb = '{8'h01, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
      repeat (3) tick();
      check("rst_wen", 32'(upg_wen_o), 32'd0);
      check("rst_adr", 32'(upg_adr_o), 32'd0);
      check("rst_dat", upg_dat_o, 32'd0);
      check("rst_done", 32'(upg_done_o), 32'd1);
      check("rst_hold", 32'(cpu_hold_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      rst = 1'b1;
      tick();

      // Two instruction words with spaced bytes.
      clr_log();
      pulse_start();
      check("start_hold", 32'(cpu_hold_o), 32'd1);
      check("start_done", 32'(upg_done_o), 32'd0);
      send_frame(fa, 1, 8'd0, -1);
      repeat (4) tick();
      check("a_nwr", d_wa.size(), 32'd2);
      chk_wr("a_w0", 0, 32'h0000, 32'h12345678);
      chk_wr("a_w1", 1, 32'h0001, 32'hDEADBEEF);
      check("m_nwr", m_wa.size(), 32'd2);
      check("m_w1_adr", (m_wa.size() > 1) ? m_wa[1] : 32'hx, 32'h0001);
      check("m_w1_dat", (m_wd.size() > 1) ? m_wd[1] : 32'hx, 32'hDEADBEEF);
      check("a_done", 32'(upg_done_o), 32'd1);
      check("a_err", 32'(err_o), 32'd0);

      // Data target, with a start pulse mid-frame that must be ignored.
      clr_log();
      pulse_start();
      send_frame(fb, 1, 8'd0, 3);
      repeat (4) tick();
      check("b_nwr", d_wa.size(), 32'd1);
      chk_wr("b_w0", 0, 32'h4000, 32'h11223344);

      // Bad target is sticky until restart.
      clr_log();
      pulse_start();
      send_byte(8'h07, 3);
      check("tgt_err", 32'(err_o), 32'd1);
      check("tgt_hold", 32'(cpu_hold_o), 32'd1);
      check("tgt_done", 32'(upg_done_o), 32'd0);
      check("tgt_nwr", d_wa.size(), 32'd0);
      pulse_start();
      check("restart_err", 32'(err_o), 32'd0);
      send_frame(fb, 0, 8'd0, -1);
      repeat (4) tick();
      check("restart_nwr", d_wa.size(), 32'd1);
      chk_wr("restart_w0", 0, 32'h4000, 32'h11223344);

      // Count above the limit, then an empty frame.
      clr_log();
      pulse_start();
      fx = '{8'h00, 8'h01, 8'h40};
      send_frame(fx, 1, 8'd0, -1);
      repeat (2) tick();
      check("cnt_err", 32'(err_o), 32'd2);
      pulse_start();
      fx = '{8'h00, 8'h00, 8'h00};
      send_frame(fx, 1, 8'd0, -1);
      repeat (3) tick();
      check("zero_err", 32'(err_o), 32'd0);
      check("zero_done", 32'(upg_done_o), 32'd1);
      check("zero_nwr", d_wa.size(), 32'd0);

      // Back-to-back bytes: one lands in the write cycle.
      clr_log();
      pulse_start();
      send_frame(fa, 0, 8'd0, -1);
      repeat (4) tick();
      check("bb_nwr", d_wa.size(), 32'd2);
      chk_wr("bb_w0", 0, 32'h0000, 32'h12345678);
      chk_wr("bb_w1", 1, 32'h0001, 32'hDEADBEEF);

      // Stray byte in idle.
      send_byte(8'h55, 2);
      check("idle_busy", 32'(busy_o), 32'd0);
      check("idle_nwr", d_wa.size(), 32'd2);

      // Stall after two data bytes.
      clr_log();
      pulse_start();
      fx = '{8'h00, 8'h01, 8'h00, 8'h11, 8'h22};
      foreach (fx[i]) send_byte(fx[i], 0);
      repeat (TMO - 1) tick();
      check("tmo_early", 32'(err_o), 32'd0);
      tick();
      check("tmo_err", 32'(err_o), 32'd3);
      check("tmo_hold", 32'(cpu_hold_o), 32'd1);
      check("tmo_nwr", d_wa.size(), 32'd0);

      // Reset mid-data.
      pulse_start();
      fx = '{8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB};
      foreach (fx[i]) send_byte(fx[i], 1);
      rst = 1'b0;
      #1;
      check("mid_wen", 32'(upg_wen_o), 32'd0);
      check("mid_adr", 32'(upg_adr_o), 32'd0);
      check("mid_dat", upg_dat_o, 32'd0);
      check("mid_done", 32'(upg_done_o), 32'd1);
      check("mid_hold", 32'(cpu_hold_o), 32'd0);
      check("mid_busy", 32'(busy_o), 32'd0);
      check("mid_err", 32'(err_o), 32'd0);
      tick();
      rst = 1'b1;
      tick();

`ifdef UPG_LOADER_CHECKSUM_EN
      clr_log();
      pulse_start();
      send_frame(fb, 1, 8'h5A, -1);
      repeat (2) tick();
      check("chk_err", 32'(err_o), 32'd3);
      check("chk_nwr", d_wa.size(), 32'd1);
`endif

      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/upg_loader.md
Name: upg_loader

Overview:
- Sequences UART program download into instruction and data memory through the upg_* programming interface.
- Receives a framed byte stream from the UART receiver and assembles little-endian 32-bit words. Issues one-cycle memory writes and holds the CPU off the memories while a download is in progress.
- Sits between the UART receiver and the memory/IFetch upg ports in cpu_top. Drives the signals currently declared as the UART programmer pinouts.

Parameters:
- ADDR_W, 14, word-address width per memory; upg_adr_o is ADDR_W+1 bits wide.
- MAX_WORDS, 16384, largest legal word count; must be ≤ 2^ADDR_W.
- TIMEOUT_CYCLES, 1000000, idle clk cycles allowed between bytes inside a frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start_i  in  1  one-cycle pulse; enters program mode.
- rx_valid_i  in  1  one-cycle strobe; rx_byte_i is valid in that cycle.
- rx_byte_i  in  8  received byte.
- upg_wen_o  out  1  memory write enable, one cycle per word.
- upg_adr_o  out  ADDR_W+1  bit[ADDR_W] selects memory (0 = instruction, 1 = data); low bits are the word index.
- upg_dat_o  out  32  assembled word.
- upg_done_o  out  1  1 = memories owned by CPU; 0 = download in progress.
- cpu_hold_o  out  1  1 = CPU held in reset/stall.
- busy_o  out  1  FSM not in IDLE.
- err_o  out  2  sticky error code: 0 none, 1 bad target, 2 count too large, 3 timeout, (checksum uses 2'b11 when CHECKSUM_EN).

Behaviour:
- Reset values: upg_wen_o=0, upg_adr_o=0, upg_dat_o=0, upg_done_o=1, cpu_hold_o=0, busy_o=0, err_o=0, FSM=IDLE.
- Reset asserted mid-download aborts immediately. Memory contents already written are not rolled back.
- Frame format: TGT byte, CNT_L, CNT_H, then CNT words of 4 bytes each, least significant byte first. With CHECKSUM_EN, one CHK byte follows the words.
- FSM states: IDLE → HDR_TGT → HDR_CNT0 → HDR_CNT1 → DATA ⇄ WRITE → (CHK) → DONE → IDLE. Any state can go to ERR.
- IDLE:
  - rx_valid_i is ignored.
  - start_i moves to HDR_TGT, clears err_o, sets cpu_hold_o=1 and upg_done_o=0 in the next cycle.
- HDR_TGT: byte 0x00 or 0x01 is latched as the target bit. Any other byte goes to ERR with code 1.
- HDR_CNT0 / HDR_CNT1: build the 16-bit count. In HDR_CNT1:
  - count > MAX_WORDS goes to ERR with code 2.
  - count == 0 goes directly to DONE (or CHK when CHECKSUM_EN).
  - otherwise go to DATA with word index 0 and byte lane 0.
- DATA:
  - Each accepted byte is placed in lane k of upg_dat_o; k increments.
  - The 4th byte moves the FSM to WRITE.
- WRITE lasts exactly one cycle:
  - upg_wen_o=1, upg_adr_o={target, index}.
  - Index increments after the write.
  - If index+1 == count, go to DONE/CHK; otherwise return to DATA.
  - A byte arriving in the WRITE cycle is captured as lane 0 of the next word, so no bytes are dropped.
- Write latency: the write is asserted in the cycle after the 4th byte's strobe.
- Timeout:
  - A counter resets on every rx_valid_i and on state entry.
  - Reaching TIMEOUT_CYCLES in any receiving state goes to ERR with code 3.
- DONE: lasts one cycle, then IDLE. upg_done_o=1 and cpu_hold_o=0 from the IDLE entry onward.
- ERR:
  - err_o is sticky; cpu_hold_o stays 1 and upg_done_o stays 0.
  - Only start_i (restart, clears err_o) or reset leaves ERR.
- start_i while busy (not IDLE/ERR) is ignored.
- Bytes after the frame completes are ignored in IDLE.
- busy_o is 1 in every state except IDLE.

Optional Feature:
- Macro UPG_LOADER_CHECKSUM_EN.
- When defined:
  - Adds the CHK state.
  - Keeps an 8-bit running sum mod 256 of all bytes from TGT through the last data byte.
  - The CHK byte must equal the two's-complement of that sum; otherwise go to ERR with code 3 and checksum flag semantics.
  - Timeout also applies in CHK.
- When undefined: no CHK state; the frame ends after the last word.

Decomposition:
- Package upg_pkg holds:
  - the state enum;
  - error code constants ERR_NONE, ERR_TGT, ERR_CNT, ERR_TMO;
  - target constants TGT_INSTR=0, TGT_DATA=1.
- One sub-module, upg_timeout: a loadable down-counter with clear and expire outputs, instantiated once.

Test Plan:
- start_i, frame 00 02 00 78 56 34 12 EF BE AD DE → two writes: adr=0x0000 dat=0x12345678, then adr=0x0001 dat=0xDEADBEEF; upg_done_o returns to 1; err_o=0.
- start_i, frame 01 01 00 44 33 22 11 → single write adr=0x4000 dat=0x11223344.
- start_i, TGT=0x07 → err_o=1, no writes, cpu_hold_o stays 1; then start_i plus a valid frame succeeds and clears err_o.
- start_i, count 0x4001 → err_o=2. start_i, count 0x0000 → DONE with no writes.
- Frame stalls after 2 data bytes for TIMEOUT_CYCLES (set to 100) → err_o=3 at cycle 100; reset asserted mid-DATA → all outputs return to reset values.
- Byte strobe coincident with the WRITE cycle → that byte lands in lane 0 of the next word; with the checksum macro defined, a wrong CHK byte → ERR.
